// File: rtl/s2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : s2_pkg
// Description : Shared constants and TX state encoding for the S2 serial
//               transposer.
// Revision    : 1.0 - initial release
// ============================================================================
package s2_pkg;

  localparam int NW           = 8;   // RB2 words, frames received
  localparam int WB           = 18;  // RB2 word width, frames transmitted
  localparam int RXA          = 3;   // address bits per received frame
  localparam int TXA          = 5;   // address bits per transmitted frame
  localparam int DB           = NW;  // data bits per transmitted frame

  localparam int RX_FRAME_LEN = RXA + WB;     // 21 low-sen cycles
  localparam int TX_FRAME_LEN = 1 + TXA + DB; // gap + address + data = 14

  typedef enum logic [2:0] {
    IDLE_RX = 3'd0,
    TX_GAP  = 3'd1,
    TX_ADDR = 3'd2,
    TX_DATA = 3'd3,
    TX_END  = 3'd4
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/s2_rx_deser.sv
`default_nettype none
// ============================================================================
// Module      : s2_rx_deser
// Description : Receive deserialiser. Shifts in a 21-bit sen-framed word
//               (3-bit address then 18-bit data, MSB first) and emits it with
//               a one-cycle valid. Short frames are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module s2_rx_deser
  import s2_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           sen,
  input  logic           sd,
  output logic [RXA-1:0] addr,
  output logic [WB-1:0]  data,
  output logic           valid
);

  logic [4:0]              r_bit_cnt;
  logic [RX_FRAME_LEN-2:0] r_shift;
  logic [RX_FRAME_LEN-1:0] w_frame;

  // Frame as it stands including the bit being sampled this edge
  assign w_frame = {r_shift, sd};

  // Shift while sen is low; sen high or a disabled receiver restarts the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      addr      <= '0;
      data      <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en || sen) begin
        r_bit_cnt <= '0;
      end else begin
        r_shift <= w_frame[RX_FRAME_LEN-2:0];
        if (r_bit_cnt == 5'(RX_FRAME_LEN - 1)) begin
          r_bit_cnt <= '0;
          valid     <= 1'b1;
          addr      <= w_frame[RX_FRAME_LEN-1 -: RXA];
          data      <= w_frame[WB-1:0];
        end else begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/s2_serial_transposer.sv
`default_nettype none
// ============================================================================
// Module      : s2_serial_transposer
// Description : S2 stage of the two-wire sen/sd bus. Receives 8 frames into
//               RB2, then transmits RB2 back column-wise as 18 frames of
//               5-bit address plus 8 data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module s2_serial_transposer
  import s2_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           updown,
  output logic           S2_done,
  output logic           RB2_RW,
  output logic [RXA-1:0] RB2_A,
  output logic [WB-1:0]  RB2_D,
  input  logic [WB-1:0]  RB2_Q,
  inout  wire            sen,
  inout  wire            sd
);

  tx_state_t      r_state;
  logic [4:0]     r_bit_cnt;
  logic [4:0]     r_frame_cnt;
  logic [RXA-1:0] r_tx_word;
  logic           r_sen_o;
  logic           r_sd_o;
  logic [3:0]     r_rx_frames;

  logic [RXA-1:0] w_rx_addr;
  logic [WB-1:0]  w_rx_data;
  logic           w_rx_valid;
  logic           w_addr_bit;
  logic [4:0]     w_data_idx;
  logic           w_data_bit;

  // Bus is released whenever S1 owns it
  assign sen = updown ? r_sen_o : 1'bz;
  assign sd  = updown ? r_sd_o  : 1'bz;

  s2_rx_deser u_rx_deser (
    .clk   (clk),
    .rst   (rst),
    .en    (~updown),
    .sen   (sen),
    .sd    (sd),
    .addr  (w_rx_addr),
    .data  (w_rx_data),
    .valid (w_rx_valid)
  );

  // RB2 port: writes come only from the receiver; TX owns the address
  assign RB2_RW = ~w_rx_valid;
  assign RB2_D  = w_rx_data;
  assign RB2_A  = (r_state == IDLE_RX) ? w_rx_addr : r_tx_word;

  // Address bit k[4..0] selected by the running bit count, data bit 17-k
  assign w_addr_bit = r_frame_cnt[3'(TXA - 1) - r_bit_cnt[2:0]];
  assign w_data_idx = 5'(WB - 1) - r_frame_cnt;
  assign w_data_bit = RB2_Q[w_data_idx];

  // Sticky done after the NW-th completed receive frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_frames <= '0;
      S2_done     <= 1'b0;
    end else if (w_rx_valid && !S2_done) begin
      r_rx_frames <= r_rx_frames + 4'd1;
      if (r_rx_frames == 4'(NW - 1)) begin
        S2_done <= 1'b1;
      end
    end
  end

  // Transmit FSM: gap, address, data per frame; RB2_A runs one cycle ahead
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE_RX;
      r_bit_cnt   <= '0;
      r_frame_cnt <= '0;
      r_tx_word   <= '0;
      r_sen_o     <= 1'b1;
      r_sd_o      <= 1'b0;
    end else if (!updown) begin
      r_state     <= IDLE_RX;
      r_bit_cnt   <= '0;
      r_frame_cnt <= '0;
      r_tx_word   <= '0;
      r_sen_o     <= 1'b1;
      r_sd_o      <= 1'b0;
    end else begin
      case (r_state)
        IDLE_RX: begin
          r_state     <= TX_GAP;
          r_bit_cnt   <= '0;
          r_frame_cnt <= '0;
          r_tx_word   <= '0;
          r_sen_o     <= 1'b1;
          r_sd_o      <= 1'b0;
        end
        TX_GAP: begin
          r_state   <= TX_ADDR;
          r_sen_o   <= 1'b0;
          r_sd_o    <= w_addr_bit;
          r_bit_cnt <= 5'd1;
        end
        TX_ADDR: begin
          if (r_bit_cnt == 5'(TXA)) begin
            r_state   <= TX_DATA;
            r_sd_o    <= w_data_bit;
            r_tx_word <= r_tx_word + 3'd1;
            r_bit_cnt <= 5'd1;
          end else begin
            r_sd_o    <= w_addr_bit;
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        TX_DATA: begin
          if (r_bit_cnt == 5'(DB)) begin
            r_sen_o   <= 1'b1;
            r_sd_o    <= 1'b0;
            r_bit_cnt <= '0;
            r_tx_word <= '0;
            if (r_frame_cnt == 5'(WB - 1)) begin
              r_state <= TX_END;
            end else begin
              r_state     <= TX_GAP;
              r_frame_cnt <= r_frame_cnt + 5'd1;
            end
          end else begin
            r_sd_o    <= w_data_bit;
            r_tx_word <= r_tx_word + 3'd1;
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        TX_END: begin
          r_sen_o <= 1'b1;
          r_sd_o  <= 1'b0;
        end
        default: begin
          r_state <= IDLE_RX;
          r_sen_o <= 1'b1;
          r_sd_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_s2_serial_transposer.sv
`default_nettype none
// ============================================================================
// Module      : tb_s2_serial_transposer
// Description : Self-checking bench: drives S1-side frames, models RB2 as a
//               RAM, and checks writes, S2_done and the transposed TX stream
//               against a simple array model of RB2 contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s2_serial_transposer;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        updown = 1'b0;
  logic        tb_sen = 1'b1;
  logic        tb_sd  = 1'b0;
  wire         sen;
  wire         sd;
  logic        S2_done;
  logic        RB2_RW;
  logic [2:0]  RB2_A;
  logic [17:0] RB2_D;
  logic [17:0] RB2_Q;

  logic [17:0] ram     [8];
  logic [17:0] ref_rb2 [8];
  int          exp_a[$], exp_d[$], got_a[$], got_d[$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign sen = updown ? 1'bz : tb_sen;
  assign sd  = updown ? 1'bz : tb_sd;

  s2_serial_transposer dut (
    .clk     (clk),
    .rst     (rst),
    .updown  (updown),
    .S2_done (S2_done),
    .RB2_RW  (RB2_RW),
    .RB2_A   (RB2_A),
    .RB2_D   (RB2_D),
    .RB2_Q   (RB2_Q),
    .sen     (sen),
    .sd      (sd)
  );

  // RB2 register bank: combinational read, write on clk when RW=0
  assign RB2_Q = ram[RB2_A];
  always @(posedge clk) if (RB2_RW === 1'b0) ram[RB2_A] <= RB2_D;

  // Record every cycle RB2_RW is low
  always @(negedge clk)
    if (!rst && RB2_RW === 1'b0) begin
      got_a.push_back(int'(RB2_A));
      got_d.push_back(int'(RB2_D));
    end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [2:0] a, input logic [17:0] d);
    logic [20:0] f;
    f = {a, d};
    for (int i = 20; i >= 0; i--) begin
      @(negedge clk);
      tb_sen = 1'b0;
      tb_sd  = f[i];
    end
    @(negedge clk);
    tb_sen = 1'b1;
    tb_sd  = 1'b0;
    exp_a.push_back(int'(a));
    exp_d.push_back(int'(d));
    ref_rb2[a] = d;
  endtask

  task automatic check_writes(input string tag);
    @(negedge clk);
    #1;
    check($sformatf("%s_count", tag), got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_a[i], exp_a[i]);
      check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
    end
    got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // Collect nfr complete TX frames and compare with the transposed model
  task automatic tx_frames(input int nfr);
    logic [13:0] sv;
    logic [4:0]  av;
    logic [7:0]  dv;
    logic [7:0]  ev;
    for (int k = 0; k < nfr; k++) begin
      @(negedge clk);
      sv[13] = sen;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        sv[12-i] = sen;
        av[4-i]  = sd;
      end
      for (int w = 0; w < 8; w++) begin
        @(negedge clk);
        sv[7-w] = sen;
        dv[7-w] = sd;
      end
      for (int w = 0; w < 8; w++) ev[7-w] = ref_rb2[w][17-k];
      check($sformatf("tx_sen_f%0d", k), 32'(sv), 32'h2000);
      check($sformatf("tx_addr_f%0d", k), 32'(av), 32'(k));
      check($sformatf("tx_data_f%0d", k), 32'(dv), 32'(ev));
    end
  endtask

  initial begin
    logic [17:0] d;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_done", 32'(S2_done), 0);
    check("rst_rw", 32'(RB2_RW), 1);
    check("rst_a", 32'(RB2_A), 0);
    check("rst_d", 32'(RB2_D), 0);
    updown = 1'b1;
    #1;
    check("rst_bus", 32'({sen, sd}), 32'h2);
    updown = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single frame
    send_frame(3'd5, 18'h2A5C3);
    check_writes("single");
    check("single_done", 32'(S2_done), 0);

    // Aborted frame, then full frame to address 2
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tb_sen = 1'b0;
      tb_sd  = 1'($urandom);
    end
    @(negedge clk);
    tb_sen = 1'b1;
    gap();
    send_frame(3'd2, 18'($urandom));
    check_writes("abort");

    // Eight frames in order, alternating ones/zeros; S2_done timing
    reset_pulse();
    for (int a = 0; a < 7; a++) begin
      send_frame(3'(a), (a % 2 == 0) ? 18'h3FFFF : 18'h0);
      gap();
    end
    send_frame(3'd7, 18'h0);
    check("eight_pulse", 32'(RB2_RW), 0);
    check("eight_done_pre", 32'(S2_done), 0);
    @(negedge clk);
    check("eight_done_rise", 32'(S2_done), 1);
    check("eight_rw_back", 32'(RB2_RW), 1);
    check_writes("eight");

    // Transmit pattern, then hold in the end state
    updown = 1'b1;
    tx_frames(18);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("tx_end%0d", i), 32'({sen, sd}), 32'h2);
    end

    // Random contents round trip
    updown = 1'b0;
    for (int a = 0; a < 8; a++) begin
      gap();
      d = 18'($urandom);
      send_frame(3'(a), d);
    end
    check_writes("rand_rx");
    check("done_hold", 32'(S2_done), 1);
    updown = 1'b1;
    tx_frames(18);

    // Drop updown during frame 6 data
    updown = 1'b0;
    for (int a = 0; a < 8; a++) send_frame(3'(a), 18'h3FFFF);
    check_writes("ones");
    updown = 1'b1;
    tx_frames(6);
    repeat (1 + 5 + 3) @(negedge clk);
    updown = 1'b0;
    tb_sen = 1'b1;
    tb_sd  = 1'b0;
    #1;
    check("drop_bus", 32'({sen, sd}), 32'h2);
    check("drop_rw", 32'(RB2_RW), 1);
    @(negedge clk);
    send_frame(3'd1, 18'($urandom));
    check_writes("drop_rx");

    // Reset in the middle of a frame
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tb_sen = 1'b0;
      tb_sd  = 1'b1;
    end
    rst = 1'b1;
    #1;
    check("mrst_done", 32'(S2_done), 0);
    check("mrst_rw", 32'(RB2_RW), 1);
    check("mrst_a", 32'(RB2_A), 0);
    check("mrst_d", 32'(RB2_D), 0);
    updown = 1'b1;
    #1;
    check("mrst_bus", 32'({sen, sd}), 32'h2);
    updown = 1'b0;
    tb_sen = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_writes("mrst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/s2_serial_transposer.md
Name: s2_serial_transposer

Overview:
- Partner stage to the S1 serial engine on the shared sen/sd two-wire bus.
- Receive phase (updown=0): captures 8 serial frames from S1 and writes them into register bank RB2 (8 words x 18 bits).
- Transmit phase (updown=1): reads RB2 back out as 18 frames of 5-bit RB1 address plus 8 data bits. S1 thereby rebuilds its 18-byte bank in transposed form.

Parameters:
- NW, 8, number of RB2 words; frames received.
- WB, 18, RB2 word width; data bits per received frame; frames transmitted.
- RXA, 3, address bits per received frame; RB2_A width.
- TXA, 5, address bits per transmitted frame.
- DB, 8, data bits per transmitted frame (= NW).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- updown  in  1  0 = S1 drives bus, block receives; 1 = block drives bus
- S2_done  out  1  receive phase complete, sticky
- RB2_RW  out  1  0 = write RB2 at next clk edge; 1 = read
- RB2_A  out  3  RB2 word address
- RB2_D  out  18  RB2 write data
- RB2_Q  in  18  RB2 read data; combinational from RB2_A
- sen  inout  1  frame enable, active-low; driven only when updown=1, else Z
- sd  inout  1  serial data; driven only when updown=1, else Z

Behaviour:
- Reset values:
  - State IDLE_RX.
  - S2_done=0, RB2_RW=1, RB2_A=0, RB2_D=0.
  - Internal sen_o=1, sd_o=0.
  - Bit counter 0; frame counter 0.
- Bus drive: sen=updown?sen_o:Z; sd=updown?sd_o:Z. Tri-state is combinational on updown.
- All bus sampling and driving occurs on the rising edge of clk.
- Receive (updown=0):
  - Frame = sen low for exactly RXA+WB=21 consecutive cycles.
  - First 3 bits form the address, MSB first. Next 18 bits form the data, MSB first; first data bit goes to RB2_D[17].
  - On the edge sampling the 21st bit: RB2_A=addr, RB2_D complete, RB2_RW=0 for exactly one cycle, then RB2_RW returns to 1.
  - sen high resets the bit counter. A frame that is aborted (sen rises before 21 bits) is discarded with no write.
  - Address field is taken from the frame, not from an internal counter.
  - Count completed frames. On the write of the 8th frame, S2_done=1 one cycle after RB2_RW=0. S2_done stays 1 until rst.
  - Frames received after S2_done are still written.
- Transmit (updown=1), states TX_GAP, TX_ADDR, TX_DATA, TX_END:
  - Entered from any state on the first edge with updown=1. The bit counter resets on entry.
  - Frame k runs k=0..17. Frame sequence:
    - One cycle of sen_o=1 (TX_GAP).
    - 5 cycles sen_o=0 with sd_o = k[4..0], MSB first (TX_ADDR).
    - 8 cycles sen_o=0 with sd_o = RB2[w][17-k] for w=0..7 in order (TX_DATA).
  - Total 14 cycles per frame. RB2_A is driven to w one cycle before the cycle sd_o carries that bit, so RB2_Q is sampled combinationally into sd_o.
  - RB2_RW=1 throughout transmit.
  - After frame 17: sen_o=1 and the block goes to TX_END, where it holds sen_o=1, sd_o=0 until rst or updown=0.
  - updown=0 mid-transmit returns the block to IDLE_RX immediately. Counters clear and sen/sd release to Z the same cycle.
- Mapping contract: the complete round trip yields RB1[k] bit (7-w) = RB2[w][17-k].
- Widths:
  - Bit counter 5 bits, saturating-free, cleared at frame boundaries.
  - Frame counter 5 bits; k=17 is the terminal value, with no wrap.
- rst mid-frame: all state and outputs return to reset values. The partial frame is not written.

Decomposition:
- Shared package s2_pkg holds:
  - constants NW, WB, RXA, TXA, DB;
  - derived RX_FRAME_LEN=21 and TX_FRAME_LEN=14;
  - TX state enum {IDLE_RX, TX_GAP, TX_ADDR, TX_DATA, TX_END}.
- One natural sub-module: s2_rx_deser, the 21-bit shift/counter that emits addr, data and a one-cycle valid. The top level owns the TX FSM, tri-state and RB2 port muxing.

Test Plan:
- Reset: assert rst mid-run -> S2_done=0, RB2_RW=1, RB2_A=0, RB2_D=0; with updown=1 the bus reads sen=1, sd=0.
- Single RX frame, addr=3'b101, data=18'h2A5C3 -> exactly one RB2_RW=0 pulse with RB2_A=5, RB2_D=18'h2A5C3; S2_done stays 0.
- Eight RX frames, addresses 0..7 in order -> 8 write pulses; S2_done rises one cycle after the 8th pulse and holds.
- Aborted RX frame (sen high after 10 bits) followed by a full frame addr 2 -> only one write, to address 2.
- TX with RB2[w]=18'h3FFFF for w even and 0 for w odd:
  - 18 frames, each 1 high + 13 low sen cycles.
  - Frame k address bits equal k.
  - Data bits = 1,0,1,0,1,0,1,0.
  - sen held high after frame 17.
- updown dropped to 0 during TX frame 6 data -> sen/sd return to Z that cycle; a subsequent RX frame addr 1 writes correctly.
